load_store_unit: RTL

- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage.
- Drives word-aligned memory beats with a byte-enable mask and lane-shifted store data.
- Returns aligned, sign- or zero-extended load data.
- Accesses that straddle a word boundary are split into two sequential beats. The block sits between the ALU/address path and the data memory.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 33 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and legality check for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } lsu_state_t;

    // Doubleword and unsigned-word accesses only exist on a 64-bit datapath;
    // unsigned variants make no sense for stores.
    function automatic logic legal_funct3(input int n, input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            F3_D:             ok = (n == 64);
            F3_WU:            ok = (n == 64) && !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signal bundle of the load/store unit
interface load_store_unit_if #(
    parameter int N = 64
);
    logic             reqValid;
    logic             reqReady;
    logic             isStore;
    logic [2:0]       funct3;
    logic [N-1:0]     address;
    logic [N-1:0]     storeData;
    logic             respValid;
    logic [N-1:0]     loadData;
    logic             accessFault;
    logic             memWriteEnable;
    logic [N/8-1:0]   memWriteMask;
    logic [N-1:0]     memAddress;
    logic [N-1:0]     memWriteData;
    logic [N-1:0]     memReadData;

    // master: the load/store unit (initiator toward memory, responder to execute)
    modport master (
        input  reqValid, isStore, funct3, address, storeData, memReadData,
        output reqReady, respValid, loadData, accessFault,
               memWriteEnable, memWriteMask, memAddress, memWriteData
    );

    // slave: execute stage plus data memory
    modport slave (
        output reqValid, isStore, funct3, address, storeData, memReadData,
        input  reqReady, respValid, loadData, accessFault,
               memWriteEnable, memWriteMask, memAddress, memWriteData
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts the two-beat read window to byte 0 and sign/zero extends to size
module lsu_load_align #(
    parameter int N  = 64,
    parameter int BL = $clog2(N / 8)
) (
    input  logic [N-1:0]  lo_i,
    input  logic [N-1:0]  hi_i,
    input  logic [BL-1:0] off_i,
    input  logic [1:0]    size_i,
    input  logic          unsigned_i,
    output logic [N-1:0]  data_o
);
    logic [2*N-1:0] shifted;
    logic [N-1:0]   window;
    logic           sign_bit;
    int             nbits;

    assign shifted = {hi_i, lo_i} >> {off_i, 3'b000};
    assign window  = shifted[N-1:0];

    // Keep the low 8*size bits and fill above with the extension bit.
    always_comb begin
        sign_bit = window[N-1];
        nbits    = N;
        case (size_i)
            2'd0: begin sign_bit = window[7];  nbits = 8;  end
            2'd1: begin sign_bit = window[15]; nbits = 16; end
            2'd2: begin sign_bit = window[31]; nbits = 32; end
            default: begin sign_bit = window[N-1]; nbits = N; end
        endcase
        for (int i = 0; i < N; i++) begin
            data_o[i] = (i < nbits) ? window[i] : (sign_bit & ~unsigned_i);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with split handling for unaligned beats
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master bus
);
    localparam int NB = N / 8;
    localparam int BL = $clog2(NB);

    lsu_state_t     state_q, state_d;
    logic           is_store_q, is_store_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [N-1:0]   store_data_q, store_data_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           resp_valid_q, resp_valid_d;
    logic [N-1:0]   load_data_q, load_data_d;
    logic           fault_q, fault_d;

    logic [BL-1:0]  off;
    logic [N-1:0]   base;
    logic [3:0]     size_b;
    logic           split;
    logic [2*NB-1:0] wide_mask;
    logic [2*N-1:0] wide_data;
    logic [N-1:0]   align_lo, align_hi, aligned;

    logic           mem_we;
    logic [NB-1:0]  mem_mask;
    logic [N-1:0]   mem_addr, mem_wdata;

    assign off       = addr_q[BL-1:0];
    assign base      = {addr_q[N-1:BL], {BL{1'b0}}};
    assign size_b    = 4'd1 << funct3_q[1:0];
    assign split     = (int'(off) + int'(size_b)) > NB;
    // Low half of the doubled mask/data feeds the LO beat, high half the HI beat.
    assign wide_mask = ~({2*NB{1'b1}} << size_b) << off;
    assign wide_data = {{N{1'b0}}, store_data_q} << {off, 3'b000};

    // On the HI beat the LO word comes from the capture register.
    assign align_lo = (state_q == HI) ? lo_q : bus.memReadData;
    assign align_hi = (state_q == HI) ? bus.memReadData : '0;

    lsu_load_align #(.N(N), .BL(BL)) u_align (
        .lo_i       (align_lo),
        .hi_i       (align_hi),
        .off_i      (off),
        .size_i     (funct3_q[1:0]),
        .unsigned_i (funct3_q[2]),
        .data_o     (aligned)
    );

    // State and latched request; reset also kills the memory beat at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            store_data_q <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            load_data_q  <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
        end
    end

    // Next state, request latch, response generation and memory beat decode.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        lo_d         = lo_q;
        resp_valid_d = 1'b0;
        load_data_d  = '0;
        fault_d      = 1'b0;
        mem_we       = 1'b0;
        mem_mask     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    is_store_d   = bus.isStore;
                    funct3_d     = bus.funct3;
                    addr_d       = bus.address;
                    store_data_d = bus.storeData;
                    if (legal_funct3(N, bus.isStore, bus.funct3)) begin
                        state_d = LO;
                    end else begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end
                end
            end
            LO: begin
                mem_we    = is_store_q;
                mem_mask  = wide_mask[NB-1:0];
                mem_addr  = base;
                mem_wdata = wide_data[N-1:0];
                lo_d      = bus.memReadData;
                if (split) begin
                    state_d = HI;
                end else begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    load_data_d  = is_store_q ? '0 : aligned;
                end
            end
            HI: begin
                mem_we       = is_store_q;
                mem_mask     = wide_mask[2*NB-1:NB];
                mem_addr     = base + N'(NB);
                mem_wdata    = wide_data[2*N-1:N];
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                load_data_d  = is_store_q ? '0 : aligned;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.reqReady       = (state_q == IDLE);
    assign bus.respValid      = resp_valid_q;
    assign bus.loadData       = load_data_q;
    assign bus.accessFault    = fault_q;
    assign bus.memWriteEnable = mem_we;
    assign bus.memWriteMask   = mem_mask;
    assign bus.memAddress     = mem_addr;
    assign bus.memWriteData   = mem_wdata;

endmodule
